// File: rtl/qa_drv_hc_types.sv
// qa_drv_hc_types: CCI, arbiter, CSR and status-manager types shared by the host channel blocks.
package qa_drv_hc_types;
  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int CCI_MDATA_WIDTH = 12;
  localparam int FIFO_IDX_BITS = 8;
  localparam int MDATA_TAG_HI = 11;
  localparam int MDATA_TAG_LO = 10;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_cldata;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_claddr;
  typedef logic [CCI_MDATA_WIDTH-1:0] t_cci_mdata;
  typedef logic [FIFO_IDX_BITS-1:0] t_fifo_from_host_idx;
  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h1,
    eREQ_WRLINE_M = 4'h2,
    eREQ_RDLINE_S = 4'h4,
    eREQ_RDLINE_I = 4'h6
  } t_cci_req;
  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_cci_vc;
  typedef struct packed {
    t_cci_req    req_type;
    t_cci_vc     vc;
    t_cci_claddr addr;
    t_cci_mdata  mdata;
  } t_cci_req_hdr;
  typedef struct packed {
    logic         request;
    t_cci_req_hdr header;
  } t_chan_req;
  typedef struct packed {
    t_chan_req read;
    t_chan_req write;
  } t_frame_arb;
  typedef struct packed {
    logic readerGrant;
    logic writerGrant;
  } t_channel_grant_arb;
  typedef struct packed {
    logic        rdValid;
    logic        wrValid;
    t_cci_mdata  mdata;
    t_cci_cldata data;
  } t_if_cci_c0_Rx;
  typedef struct packed {
    logic        hc_en;
    t_cci_claddr hc_read_frame;
  } t_qa_drv_hc_csrs;
  typedef struct packed {
    t_fifo_from_host_idx newestReadIdx;
  } t_from_status_mgr_fifo_from_host;
  typedef struct packed {
    t_fifo_from_host_idx oldestReadIdx;
  } t_to_status_mgr_fifo_from_host;
endpackage

// File: rtl/qa_drv_hc_fifo_from_host_rob.sv
// qa_drv_hc_fifo_from_host_rob: reorder buffer; responses land by slot, head is read and cleared in order.
module qa_drv_hc_fifo_from_host_rob
  import qa_drv_hc_types::*;
#(
  parameter int N_ENTRIES = 8,
  localparam int SW = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alloc,
  input  logic [SW-1:0] alloc_slot,
  input  logic          resp,
  input  logic [SW-1:0] resp_slot,
  input  t_cci_cldata   resp_data,
  input  logic          pop,
  input  logic [SW-1:0] head_slot,
  output logic          head_valid,
  output t_cci_cldata   head_data
);
  logic [N_ENTRIES-1:0] valid_q, valid_d, pending_q, pending_d;
  t_cci_cldata line_q [N_ENTRIES];
  t_cci_cldata line_d [N_ENTRIES];
  logic accept;
  // Only slots with a read in flight may be written; stale or duplicate responses fall through.
  assign accept = resp && pending_q[resp_slot];
  assign head_valid = valid_q[head_slot];
  assign head_data = line_q[head_slot];
  always_comb begin
    valid_d = valid_q;
    pending_d = pending_q;
    line_d = line_q;
    if (alloc) pending_d[alloc_slot] = 1'b1;
    if (accept) begin
      pending_d[resp_slot] = 1'b0;
      valid_d[resp_slot] = 1'b1;
      line_d[resp_slot] = resp_data;
    end
    if (pop) valid_d[head_slot] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      pending_q <= '0;
    end else begin
      valid_q <= valid_d;
      pending_q <= pending_d;
    end
    line_q <= line_d;
  end
endmodule

// File: rtl/qa_drv_hc_fifo_from_host.sv
// qa_drv_hc_fifo_from_host: host ring reader with out-of-order response reordering and in-order delivery.
// QA_DRV_HC_FIFO_FROM_HOST_OUT_REG_EN adds a one-entry output register (delivery latency t+2).
module qa_drv_hc_fifo_from_host
  import qa_drv_hc_types::*;
#(
  parameter int         N_BUF_ENTRIES = 8,
  parameter logic [1:0] MDATA_TAG = 2'b01
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  t_if_cci_c0_Rx                   rx0,
  input  t_qa_drv_hc_csrs                 csr,
  output t_frame_arb                      frame_reader,
  input  t_channel_grant_arb              read_grant,
  input  t_from_status_mgr_fifo_from_host status_to_fifo_from_host,
  output t_to_status_mgr_fifo_from_host   fifo_from_host_to_status,
  output t_cci_cldata                     rx_data,
  output logic                            rx_rdy,
  input  logic                            rx_enable
);
  localparam int SW = $clog2(N_BUF_ENTRIES);
  localparam t_fifo_from_host_idx IDX_ONE = 1;
  t_fifo_from_host_idx req_idx_q, req_idx_d, deq_idx_q, deq_idx_d, oldest_q, oldest_d, hd_idx, in_flight;
  logic issue, grant, deq, rob_pop, resp_hit, head_valid, unused;
  t_cci_cldata head_data;
  assign in_flight = req_idx_q - deq_idx_q;
  assign issue = reset_n && csr.hc_en && (req_idx_q != status_to_fifo_from_host.newestReadIdx) &&
                 (in_flight < t_fifo_from_host_idx'(N_BUF_ENTRIES));
  assign grant = issue && read_grant.readerGrant;
  assign resp_hit = rx0.rdValid && (rx0.mdata[MDATA_TAG_HI:MDATA_TAG_LO] == MDATA_TAG);
  assign deq = rx_enable && rx_rdy;
  assign fifo_from_host_to_status = '{oldestReadIdx: oldest_q};
  assign unused = ^{rx0.wrValid, rx0.mdata[MDATA_TAG_LO-1:SW], read_grant.writerGrant, hd_idx[FIFO_IDX_BITS-1:SW]};
  always_comb begin
    frame_reader = '0;
    frame_reader.read.request = issue;
    frame_reader.read.header.req_type = eREQ_RDLINE_S;
    frame_reader.read.header.vc = eVC_VA;
    frame_reader.read.header.addr = csr.hc_read_frame + t_cci_claddr'(req_idx_q);
    frame_reader.read.header.mdata = {MDATA_TAG, {(CCI_MDATA_WIDTH-2-SW){1'b0}}, req_idx_q[SW-1:0]};
  end
  always_comb begin
    req_idx_d = grant ? req_idx_q + IDX_ONE : req_idx_q;
    deq_idx_d = deq ? deq_idx_q + IDX_ONE : deq_idx_q;
    oldest_d = deq_idx_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_idx_q <= '0;
      deq_idx_q <= '0;
      oldest_q <= '0;
    end else begin
      req_idx_q <= req_idx_d;
      deq_idx_q <= deq_idx_d;
      oldest_q <= oldest_d;
    end
  end
`ifdef QA_DRV_HC_FIFO_FROM_HOST_OUT_REG_EN
  // The ROB head runs at most one line ahead of deq_idx; that line sits in the output register.
  t_fifo_from_host_idx hd_idx_q, hd_idx_d;
  logic out_vld_q, out_vld_d;
  t_cci_cldata out_data_q, out_data_d;
  assign rob_pop = head_valid && (!out_vld_q || deq);
  assign hd_idx = hd_idx_q;
  assign rx_rdy = out_vld_q;
  assign rx_data = out_data_q;
  always_comb begin
    hd_idx_d = rob_pop ? hd_idx_q + IDX_ONE : hd_idx_q;
    out_vld_d = rob_pop || (out_vld_q && !deq);
    out_data_d = rob_pop ? head_data : out_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hd_idx_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      hd_idx_q <= hd_idx_d;
      out_vld_q <= out_vld_d;
    end
    out_data_q <= out_data_d;
  end
`else
  assign rob_pop = deq;
  assign hd_idx = deq_idx_q;
  assign rx_rdy = head_valid;
  assign rx_data = head_data;
`endif
  qa_drv_hc_fifo_from_host_rob #(.N_ENTRIES(N_BUF_ENTRIES)) rob (
    .clk(clk),
    .reset_n(reset_n),
    .alloc(grant),
    .alloc_slot(req_idx_q[SW-1:0]),
    .resp(resp_hit),
    .resp_slot(rx0.mdata[SW-1:0]),
    .resp_data(rx0.data),
    .pop(rob_pop),
    .head_slot(hd_idx[SW-1:0]),
    .head_valid(head_valid),
    .head_data(head_data)
  );
endmodule
